// File: rtl/alu_scheduler_if.sv
// Requester handshakes, ALU-side wiring and status of the shared ALU scheduler.
// The slave modport is the scheduler; the master modport is the surrounding core.
interface alu_scheduler_if;
  logic        req0, fwe0, gnt0, done0;
  logic [2:0]  op0;
  logic [15:0] a0, b0;
  logic        req1, fwe1, gnt1, done1;
  logic [2:0]  op1;
  logic [15:0] a1, b1;
  logic [2:0]  alu_operation;
  logic [15:0] alu_operand1, alu_operand2, alu_result;
  logic        alu_carry;
  logic        flags_ld;
  logic [2:0]  flags_ld_val;
  logic [15:0] result;
  logic [2:0]  flags;
  logic        busy;

  modport slave (
    input  req0, op0, a0, b0, fwe0, req1, op1, a1, b1, fwe1,
    input  alu_result, alu_carry, flags_ld, flags_ld_val,
    output gnt0, done0, gnt1, done1,
    output alu_operation, alu_operand1, alu_operand2,
    output result, flags, busy
  );

  modport master (
    output req0, op0, a0, b0, fwe0, req1, op1, a1, b1, fwe1,
    output alu_result, alu_carry, flags_ld, flags_ld_val,
    input  gnt0, done0, gnt1, done1,
    input  alu_operation, alu_operand1, alu_operand2,
    input  result, flags, busy
  );
endinterface

// File: rtl/alu_scheduler.sv
// Arbitrates the shared 16-bit ALU between execute (req0) and the SP/address unit
// (req1), sequences each operation and owns the {N,Z,C} condition codes.
//
// state | meaning
// IDLE  | no operation in flight; grant point
// EXEC  | latched op/operands drive the ALU; result/flags captured at cycle end
// DONE  | done pulses to the owner; also a grant point for back-to-back issue
module alu_scheduler #(
  parameter int MAX_WAIT = 8,
  parameter int WAIT_W   = 4
) (
  input logic          clk,
  input logic          reset_b,
  alu_scheduler_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              gnt0, gnt1, pick1;
  logic              owner, fwe_q;
  logic [2:0]        op_q;
  logic [15:0]       opa_q, opb_q;
  logic [15:0]       result_q;
  logic [2:0]        flags_q;

  // Requester 1 wins when starved or when requester 0 is absent.
  assign pick1 = bus.req1 && ((wait_cnt == WAIT_MAX) || !bus.req0);

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (bus.req0 || bus.req1) begin
          gnt1      = pick1;
          gnt0      = !pick1;
          state_nxt = EXEC;
        end else begin
          state_nxt = IDLE;
        end
      end
      EXEC:    state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      owner <= 1'b0;
      fwe_q <= 1'b0;
      op_q  <= 3'd0;
      opa_q <= 16'd0;
      opb_q <= 16'd0;
    end else if (gnt0 || gnt1) begin
      owner <= gnt1;
      fwe_q <= gnt1 ? bus.fwe1 : bus.fwe0;
      op_q  <= gnt1 ? bus.op1  : bus.op0;
      opa_q <= gnt1 ? bus.a1   : bus.a0;
      opb_q <= gnt1 ? bus.b1   : bus.b0;
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b)                  wait_cnt <= '0;
    else if (gnt1 || !bus.req1)    wait_cnt <= '0;
    else if (wait_cnt != WAIT_MAX) wait_cnt <= wait_cnt + 1'b1;
  end

  // flags_ld is applied last so a context restore beats any ALU flag update.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      result_q <= 16'd0;
      flags_q  <= 3'd0;
    end else begin
      if (state == EXEC) begin
        case (op_q)
          3'b000: begin
            result_q <= bus.alu_result;
            if (fwe_q)
              flags_q <= {bus.alu_result[15], bus.alu_result == 16'd0, bus.alu_carry};
          end
          3'b001: begin
            if (fwe_q) flags_q[0] <= 1'b1;
          end
          3'b111: begin
          end
          default: begin
            result_q <= bus.alu_result;
            if (fwe_q)
              flags_q[2:1] <= {bus.alu_result[15], bus.alu_result == 16'd0};
          end
        endcase
      end
      if (bus.flags_ld) flags_q <= bus.flags_ld_val;
    end
  end

  assign bus.gnt0          = gnt0;
  assign bus.gnt1          = gnt1;
  assign bus.done0         = (state == DONE) && !owner;
  assign bus.done1         = (state == DONE) && owner;
  assign bus.busy          = (state == EXEC);
  assign bus.alu_operation = op_q;
  assign bus.alu_operand1  = opa_q;
  assign bus.alu_operand2  = opb_q;
  assign bus.result        = result_q;
  assign bus.flags         = flags_q;

endmodule

// File: tb/tb_alu_scheduler.sv
// Bench for alu_scheduler: directed scenarios plus random traffic, checked against
// a cycle-indexed schedule model that applies the arbitration and flag rules directly.
module tb_alu_scheduler;

  localparam int MAX_WAIT = 8;

  logic clk = 1'b0;
  logic reset_b = 1'b0;
  alu_scheduler_if bus();

  alu_scheduler #(.MAX_WAIT(MAX_WAIT), .WAIT_W(4)) dut (
    .clk     (clk),
    .reset_b (reset_b),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Behavioural ALU; ops without an arithmetic result return junk on purpose.
  function automatic logic [16:0] alu_fn(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      3'd0:    return {1'b0, a} + {1'b0, b};
      3'd2:    return {1'b0, a - b};
      3'd3:    return {1'b0, a & b};
      3'd4:    return {1'b0, ~a};
      3'd5:    return {1'b0, a};
      3'd6:    return {1'b0, b};
      default: return 17'h1_A5A5;
    endcase
  endfunction

  assign {bus.alu_carry, bus.alu_result} = alu_fn(bus.alu_operation, bus.alu_operand1, bus.alu_operand2);

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  int          t, next_ok, g_cycle, g_who, wcnt;
  logic [2:0]  g_op;
  logic [15:0] g_a, g_b;
  logic        g_fwe;
  logic [15:0] m_res;
  logic [2:0]  m_flags;
  logic        m_g0, m_g1, d_g0, d_g1;

  task automatic model_reset();
    t = 0; next_ok = 0; g_cycle = -10; g_who = 0; wcnt = 0;
    g_op = 3'd0; g_a = 16'd0; g_b = 16'd0; g_fwe = 1'b0;
    m_res = 16'd0; m_flags = 3'd0; m_g0 = 1'b0; m_g1 = 1'b0;
  endtask

  task automatic ref_exec(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b, input logic fwe);
    logic [16:0] sum;
    logic [15:0] r;
    if (op == 3'd0) begin
      sum = {1'b0, a} + {1'b0, b};
      m_res = sum[15:0];
      if (fwe) m_flags = {sum[15], sum[15:0] == 16'd0, sum[16]};
    end else if (op == 3'd1) begin
      if (fwe) m_flags[0] = 1'b1;
    end else if (op != 3'd7) begin
      case (op)
        3'd2:    r = a - b;
        3'd3:    r = a & b;
        3'd4:    r = ~a;
        3'd5:    r = a;
        default: r = b;
      endcase
      m_res = r;
      if (fwe) m_flags[2:1] = {r[15], r == 16'd0};
    end
  endtask

  // One clock cycle: entered at a negedge with inputs already driven.
  task automatic cycle();
    logic eg0, eg1, ebusy;
    #1;
    eg0 = 1'b0;
    eg1 = 1'b0;
    if (t >= next_ok && (bus.req0 || bus.req1)) begin
      if (bus.req1 && (wcnt == MAX_WAIT || !bus.req0)) eg1 = 1'b1;
      else                                             eg0 = 1'b1;
    end
    ebusy = (t == g_cycle + 1);
    d_g0 = bus.gnt0;
    d_g1 = bus.gnt1;
    check("gnt0", 16'(bus.gnt0), 16'(eg0));
    check("gnt1", 16'(bus.gnt1), 16'(eg1));
    check("gnt_excl", 16'(bus.gnt0 & bus.gnt1), 16'd0);
    check("done0", 16'(bus.done0), 16'((t == g_cycle + 2) && g_who == 0));
    check("done1", 16'(bus.done1), 16'((t == g_cycle + 2) && g_who == 1));
    check("busy", 16'(bus.busy), 16'(ebusy));
    check("result", bus.result, m_res);
    check("flags", 16'(bus.flags), 16'(m_flags));
    if (ebusy) begin
      check("alu_operation", 16'(bus.alu_operation), 16'(g_op));
      check("alu_operand1", bus.alu_operand1, g_a);
      check("alu_operand2", bus.alu_operand2, g_b);
      ref_exec(g_op, g_a, g_b, g_fwe);
    end
    if (bus.flags_ld) m_flags = bus.flags_ld_val;
    if (eg1 || !bus.req1)     wcnt = 0;
    else if (wcnt < MAX_WAIT) wcnt++;
    if (eg0 || eg1) begin
      g_cycle = t;
      g_who   = eg1 ? 1 : 0;
      g_op    = eg1 ? bus.op1  : bus.op0;
      g_a     = eg1 ? bus.a1   : bus.a0;
      g_b     = eg1 ? bus.b1   : bus.b0;
      g_fwe   = eg1 ? bus.fwe1 : bus.fwe0;
      next_ok = t + 2;
    end
    m_g0 = eg0;
    m_g1 = eg1;
    t++;
    @(negedge clk);
  endtask

  // Issue one request, hold until granted, then let it run to completion.
  task automatic run_op(input int r, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic fwe);
    int guard;
    guard = 0;
    if (r == 0) begin
      bus.req0 = 1'b1; bus.op0 = op; bus.a0 = a; bus.b0 = b; bus.fwe0 = fwe;
    end else begin
      bus.req1 = 1'b1; bus.op1 = op; bus.a1 = a; bus.b1 = b; bus.fwe1 = fwe;
    end
    do begin
      cycle();
      guard++;
    end while (!(r == 0 ? d_g0 : d_g1) && guard < 50);
    if (guard >= 50) check("grant_timeout", 16'd0, 16'd1);
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    cycle();
    cycle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n0;
    logic got1;
    bus.req0 = 1'b0; bus.op0 = 3'd0; bus.a0 = 16'd0; bus.b0 = 16'd0; bus.fwe0 = 1'b0;
    bus.req1 = 1'b0; bus.op1 = 3'd0; bus.a1 = 16'd0; bus.b1 = 16'd0; bus.fwe1 = 1'b0;
    bus.flags_ld = 1'b0; bus.flags_ld_val = 3'd0;
    model_reset();

    #1;
    check("rst_gnt0", 16'(bus.gnt0), 16'd0);
    check("rst_done0", 16'(bus.done0), 16'd0);
    check("rst_done1", 16'(bus.done1), 16'd0);
    check("rst_busy", 16'(bus.busy), 16'd0);
    check("rst_result", bus.result, 16'd0);
    check("rst_flags", 16'(bus.flags), 16'd0);
    check("rst_alu_op", 16'(bus.alu_operation), 16'd0);
    check("rst_alu_a", bus.alu_operand1, 16'd0);
    @(negedge clk);
    @(negedge clk);
    reset_b = 1'b1;

    // add with carry-out to zero
    run_op(0, 3'b000, 16'hFFFF, 16'h0001, 1'b1);
    check("t1_result", bus.result, 16'h0000);
    check("t1_flags", 16'(bus.flags), 16'b011);

    // sub keeps the carry
    run_op(0, 3'b010, 16'd5, 16'd7, 1'b1);
    check("t2_result", bus.result, 16'hFFFE);
    check("t2_flags", 16'(bus.flags), 16'b101);

    // set-c from requester 1 with and without flag write
    bus.flags_ld = 1'b1; bus.flags_ld_val = 3'b000;
    cycle();
    bus.flags_ld = 1'b0;
    run_op(1, 3'b001, 16'h1234, 16'h4321, 1'b0);
    check("t4a_result", bus.result, 16'hFFFE);
    check("t4a_flags", 16'(bus.flags), 16'b000);
    run_op(1, 3'b001, 16'h1234, 16'h4321, 1'b1);
    check("t4b_result", bus.result, 16'hFFFE);
    check("t4b_flags", 16'(bus.flags), 16'b001);

    // flags_ld collides with an add that would set Z
    bus.req0 = 1'b1; bus.op0 = 3'b000; bus.a0 = 16'd0; bus.b0 = 16'd0; bus.fwe0 = 1'b1;
    cycle();
    bus.req0 = 1'b0;
    bus.flags_ld = 1'b1; bus.flags_ld_val = 3'b100;
    cycle();
    bus.flags_ld = 1'b0;
    cycle();
    check("t5_result", bus.result, 16'h0000);
    check("t5_flags", 16'(bus.flags), 16'b100);

    // starvation: both requesters held high continuously
    n0 = 0;
    got1 = 1'b0;
    bus.req0 = 1'b1; bus.op0 = 3'b011; bus.a0 = 16'h00FF; bus.b0 = 16'h0F0F; bus.fwe0 = 1'b0;
    bus.req1 = 1'b1; bus.op1 = 3'b101; bus.a1 = 16'h8000; bus.b1 = 16'h0001; bus.fwe1 = 1'b1;
    for (int i = 0; i < 40 && !got1; i++) begin
      cycle();
      if (d_g0) n0++;
      if (d_g1) got1 = 1'b1;
    end
    check("t3_gnt0_before_gnt1", 16'(n0), 16'd4);
    check("t3_gnt1_seen", 16'(got1), 16'd1);
    bus.req1 = 1'b0;
    cycle();
    bus.req0 = 1'b0;
    cycle();
    cycle();
    cycle();

    // reset in the middle of EXEC
    bus.req0 = 1'b1; bus.op0 = 3'b000; bus.a0 = 16'h1234; bus.b0 = 16'h0001; bus.fwe0 = 1'b1;
    cycle();
    bus.req0 = 1'b0;
    #1;
    check("t6_pre_busy", 16'(bus.busy), 16'd1);
    #1;
    reset_b = 1'b0;
    #1;
    check("t6_busy", 16'(bus.busy), 16'd0);
    check("t6_result", bus.result, 16'd0);
    check("t6_flags", 16'(bus.flags), 16'd0);
    check("t6_done0", 16'(bus.done0), 16'd0);
    @(negedge clk);
    check("t6_done0_hold", 16'(bus.done0), 16'd0);
    @(negedge clk);
    reset_b = 1'b1;
    model_reset();
    run_op(0, 3'b110, 16'h0000, 16'h8001, 1'b1);
    check("t6_after_result", bus.result, 16'h8001);
    check("t6_after_flags", 16'(bus.flags), 16'b100);

    // random traffic with withdrawals and flag loads
    for (int i = 0; i < 500; i++) begin
      if (!bus.req0 && $urandom_range(2) == 0) begin
        bus.req0 = 1'b1;
        bus.op0  = 3'($urandom_range(7));
        bus.a0   = ($urandom_range(3) == 0) ? 16'd0 : 16'($urandom);
        bus.b0   = ($urandom_range(3) == 0) ? 16'd0 : 16'($urandom);
        bus.fwe0 = 1'($urandom_range(1));
      end else if (bus.req0 && $urandom_range(15) == 0) begin
        bus.req0 = 1'b0;
      end
      if (!bus.req1 && $urandom_range(2) == 0) begin
        bus.req1 = 1'b1;
        bus.op1  = 3'($urandom_range(7));
        bus.a1   = ($urandom_range(3) == 0) ? 16'd0 : 16'($urandom);
        bus.b1   = ($urandom_range(3) == 0) ? 16'd0 : 16'($urandom);
        bus.fwe1 = 1'($urandom_range(1));
      end else if (bus.req1 && $urandom_range(31) == 0) begin
        bus.req1 = 1'b0;
      end
      bus.flags_ld     = ($urandom_range(15) == 0);
      bus.flags_ld_val = 3'($urandom_range(7));
      cycle();
      if (m_g0) bus.req0 = 1'b0;
      if (m_g1) bus.req1 = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
